// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared encodings and defaults for the PC redirect controller.
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_TRAP = 2'd0,
        SRC_BR   = 2'd1,
        SRC_RPL  = 2'd2
    } src_t;

    localparam int DEF_EPOCH_W      = 3;
    localparam int DEF_FLUSH_CYCLES = 2;

endpackage

// File: rtl/pc_redirect_prio.sv
// Stale-epoch filter and fixed-priority pick (trap > br > rpl) among fresh redirect requests.
module pc_redirect_prio
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int EPOCH_W = DEF_EPOCH_W
) (
    input  logic               trap_valid,
    input  logic [31:0]        trap_pc,
    input  logic               br_valid,
    input  logic [31:0]        br_pc,
    input  logic [EPOCH_W-1:0] br_epoch,
    input  logic               rpl_valid,
    input  logic [31:0]        rpl_pc,
    input  logic [EPOCH_W-1:0] rpl_epoch,
    input  logic [EPOCH_W-1:0] cur_epoch,
    output logic               win_valid,
    output src_t               win_src,
    output logic [31:0]        win_pc,
    output logic               br_drop,
    output logic               rpl_drop
);

    logic br_fresh;
    logic rpl_fresh;

    assign br_fresh  = br_valid && (br_epoch == cur_epoch);
    assign rpl_fresh = rpl_valid && (rpl_epoch == cur_epoch);
    assign br_drop   = br_valid && (br_epoch != cur_epoch);
    assign rpl_drop  = rpl_valid && (rpl_epoch != cur_epoch);

    always_comb begin
        win_valid = 1'b0;
        win_src   = SRC_TRAP;
        win_pc    = 32'd0;
        if (trap_valid) begin
            win_valid = 1'b1;
            win_src   = SRC_TRAP;
            win_pc    = trap_pc;
        end else if (br_fresh) begin
            win_valid = 1'b1;
            win_src   = SRC_BR;
            win_pc    = br_pc;
        end else if (rpl_fresh) begin
            win_valid = 1'b1;
            win_src   = SRC_RPL;
            win_pc    = rpl_pc;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Sequences trap/branch/replay redirects into the PC register, tracking the fetch epoch
// and holding a settle window after every issued redirect.
//
// Handshake rule on every port: a transfer happens on a clock edge where valid && ready;
// the requester holds valid and payload until then. Stale br/rpl requests are completed
// (ready=1) without effect. arb_tx_pc may only change while valid=1 through a trap overwrite.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int EPOCH_W      = DEF_EPOCH_W,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trap_valid,
    output logic               trap_ready,
    input  logic [31:0]        trap_pc,
    input  logic               br_valid,
    output logic               br_ready,
    input  logic [31:0]        br_pc,
    input  logic [EPOCH_W-1:0] br_epoch,
    input  logic               rpl_valid,
    output logic               rpl_ready,
    input  logic [31:0]        rpl_pc,
    input  logic [EPOCH_W-1:0] rpl_epoch,
    output logic               arb_tx_valid,
    input  logic               arb_tx_ready,
    output logic [31:0]        arb_tx_pc,
    output logic               flush,
    output logic [EPOCH_W-1:0] cur_epoch,
    output logic [CNT_W-1:0]   redirect_cnt,
    output state_t             fsm_state
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    state_t             state, state_d;
    src_t               pend_src, pend_src_d;
    logic               valid_d;
    logic [31:0]        pc_d;
    logic               flush_d;
    logic [EPOCH_W-1:0] epoch_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [FC_W-1:0]    fc_q, fc_d;

    logic               win_valid;
    src_t               win_src;
    logic [31:0]        win_pc;
    logic               br_drop;
    logic               rpl_drop;
    logic               hs;
    logic               win_take;
    logic               trap_take;

    pc_redirect_prio #(
        .EPOCH_W (EPOCH_W)
    ) u_prio (
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .br_valid   (br_valid),
        .br_pc      (br_pc),
        .br_epoch   (br_epoch),
        .rpl_valid  (rpl_valid),
        .rpl_pc     (rpl_pc),
        .rpl_epoch  (rpl_epoch),
        .cur_epoch  (cur_epoch),
        .win_valid  (win_valid),
        .win_src    (win_src),
        .win_pc     (win_pc),
        .br_drop    (br_drop),
        .rpl_drop   (rpl_drop)
    );

    assign hs        = arb_tx_valid && arb_tx_ready;
    assign fsm_state = state;

    always_comb begin
        state_d    = state;
        pend_src_d = pend_src;
        valid_d    = arb_tx_valid;
        pc_d       = arb_tx_pc;
        flush_d    = 1'b0;
        epoch_d    = cur_epoch;
        cnt_d      = redirect_cnt;
        fc_d       = fc_q;
        win_take   = 1'b0;
        trap_take  = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_valid) begin
                    win_take   = 1'b1;
                    state_d    = S_PEND;
                    pend_src_d = win_src;
                    valid_d    = 1'b1;
                    pc_d       = win_pc;
                end
            end
            S_PEND: begin
                // A handshake wins over a concurrent trap; that trap is taken in S_FLUSH.
                if (hs) begin
                    state_d = S_FLUSH;
                    valid_d = 1'b0;
                    flush_d = 1'b1;
                    epoch_d = cur_epoch + EPOCH_W'(1);
                    cnt_d   = redirect_cnt + CNT_W'(1);
                    fc_d    = FC_W'(FLUSH_CYCLES);
                end else if (trap_valid && (pend_src != SRC_TRAP)) begin
                    trap_take  = 1'b1;
                    pend_src_d = SRC_TRAP;
                    pc_d       = trap_pc;
                end
            end
            S_FLUSH: begin
                fc_d = fc_q - FC_W'(1);
                if (trap_valid) begin
                    trap_take  = 1'b1;
                    state_d    = S_PEND;
                    pend_src_d = SRC_TRAP;
                    valid_d    = 1'b1;
                    pc_d       = trap_pc;
                end else if (fc_q <= FC_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign trap_ready = !rst && (trap_take || (win_take && (win_src == SRC_TRAP)));
    assign br_ready   = !rst && (br_drop || (win_take && (win_src == SRC_BR)));
    assign rpl_ready  = !rst && (rpl_drop || (win_take && (win_src == SRC_RPL)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pend_src     <= SRC_TRAP;
            arb_tx_valid <= 1'b0;
            arb_tx_pc    <= 32'd0;
            flush        <= 1'b0;
            cur_epoch    <= '0;
            redirect_cnt <= '0;
            fc_q         <= '0;
        end else begin
            state        <= state_d;
            pend_src     <= pend_src_d;
            arb_tx_valid <= valid_d;
            arb_tx_pc    <= pc_d;
            flush        <= flush_d;
            cur_epoch    <= epoch_d;
            redirect_cnt <= cnt_d;
            fc_q         <= fc_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_pc_redirect_ctrl;
    import pc_redirect_ctrl_pkg::*;

    localparam int EPOCH_W      = 3;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               trap_valid, trap_ready;
    logic [31:0]        trap_pc;
    logic               br_valid, br_ready;
    logic [31:0]        br_pc;
    logic [EPOCH_W-1:0] br_epoch;
    logic               rpl_valid, rpl_ready;
    logic [31:0]        rpl_pc;
    logic [EPOCH_W-1:0] rpl_epoch;
    logic               arb_tx_valid, arb_tx_ready;
    logic [31:0]        arb_tx_pc;
    logic               flush;
    logic [EPOCH_W-1:0] cur_epoch;
    logic [CNT_W-1:0]   redirect_cnt;
    state_t             fsm_state;

    pc_redirect_ctrl #(
        .EPOCH_W      (EPOCH_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trap_valid   (trap_valid),
        .trap_ready   (trap_ready),
        .trap_pc      (trap_pc),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .br_pc        (br_pc),
        .br_epoch     (br_epoch),
        .rpl_valid    (rpl_valid),
        .rpl_ready    (rpl_ready),
        .rpl_pc       (rpl_pc),
        .rpl_epoch    (rpl_epoch),
        .arb_tx_valid (arb_tx_valid),
        .arb_tx_ready (arb_tx_ready),
        .arb_tx_pc    (arb_tx_pc),
        .flush        (flush),
        .cur_epoch    (cur_epoch),
        .redirect_cnt (redirect_cnt),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Transaction-level model: one pending redirect, an epoch number, a redirect count
    // and the number of settle cycles still owed after the last issued redirect.
    bit          m_pend, m_pend_trap, m_flush;
    logic [31:0] m_pc;
    int          m_epoch, m_cnt, m_settle;
    bit          e_hs, e_trap_ok, e_br_ok, e_rpl_ok;
    bit          e_trap_rdy, e_br_rdy, e_rpl_rdy;

    task automatic model_reset();
        m_pend = 0; m_pend_trap = 0; m_flush = 0; m_pc = 32'd0;
        m_epoch = 0; m_cnt = 0; m_settle = 0;
    endtask

    task automatic model_eval();
        bit br_fresh, rpl_fresh, idle;
        br_fresh  = br_valid && (int'(br_epoch) == m_epoch);
        rpl_fresh = rpl_valid && (int'(rpl_epoch) == m_epoch);
        idle      = !m_pend && (m_settle == 0);
        e_hs      = m_pend && arb_tx_ready;
        e_trap_ok = trap_valid && (!m_pend || (!m_pend_trap && !e_hs));
        e_br_ok   = idle && br_fresh && !trap_valid;
        e_rpl_ok  = idle && rpl_fresh && !trap_valid && !br_fresh;
        e_trap_rdy = !rst && e_trap_ok;
        e_br_rdy   = !rst && (e_br_ok || (br_valid && !br_fresh));
        e_rpl_rdy  = !rst && (e_rpl_ok || (rpl_valid && !rpl_fresh));
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            m_flush = e_hs;
            if (e_hs) begin
                m_pend = 0;
                m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
                m_cnt++;
                m_settle = FLUSH_CYCLES;
            end else if (e_trap_ok) begin
                m_pend = 1; m_pend_trap = 1; m_pc = trap_pc; m_settle = 0;
            end else if (e_br_ok) begin
                m_pend = 1; m_pend_trap = 0; m_pc = br_pc;
            end else if (e_rpl_ok) begin
                m_pend = 1; m_pend_trap = 0; m_pc = rpl_pc;
            end else if (!m_pend && m_settle > 0) begin
                m_settle--;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        trap_valid = 0; trap_pc = 32'd0;
        br_valid = 0; br_pc = 32'd0; br_epoch = '0;
        rpl_valid = 0; rpl_pc = 32'd0; rpl_epoch = '0;
        arb_tx_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        trap_valid = 1; br_valid = 1; br_epoch = 3'd4; rpl_valid = 1; arb_tx_ready = 1;
        tick();
        @(negedge clk);
        checks++; if (arb_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", arb_tx_valid); end
        checks++; if (arb_tx_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", arb_tx_pc); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b want 0", flush); end
        checks++; if (cur_epoch !== 3'd0) begin errors++; $display("FAIL reset_epoch: got %0d want 0", cur_epoch); end
        checks++; if (redirect_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", redirect_cnt); end
        checks++; if ({trap_ready, br_ready, rpl_ready} !== 3'b000) begin errors++; $display("FAIL reset_readies: got %b want 000", {trap_ready, br_ready, rpl_ready}); end
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_IDLE); end
        clear_inputs();
        rst = 0;
        tick();
    endtask

    task automatic test_single_br();
        do_reset();
        br_valid = 1; br_pc = 32'h8000_0100; br_epoch = 3'd0; arb_tx_ready = 1;
        @(negedge clk);
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL single_br_ready: got %0b want 1", br_ready); end
        checks++; if (arb_tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_c0: got %0b want 0", arb_tx_valid); end
        tick();
        br_valid = 0;
        @(negedge clk);
        checks++; if (arb_tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid_c1: got %0b want 1", arb_tx_valid); end
        checks++; if (arb_tx_pc !== 32'h8000_0100) begin errors++; $display("FAIL single_pc_c1: got %h want 80000100", arb_tx_pc); end
        tick();
        @(negedge clk);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL single_flush_c2: got %0b want 1", flush); end
        checks++; if (arb_tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_c2: got %0b want 0", arb_tx_valid); end
        checks++; if (cur_epoch !== 3'd1) begin errors++; $display("FAIL single_epoch_c2: got %0d want 1", cur_epoch); end
        checks++; if (redirect_cnt !== 32'd1) begin errors++; $display("FAIL single_cnt_c2: got %0d want 1", redirect_cnt); end
        tick();
        @(negedge clk);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL single_flush_c3: got %0b want 0", flush); end
        checks++; if (fsm_state !== S_FLUSH) begin errors++; $display("FAIL single_state_c3: got %0d want %0d", fsm_state, S_FLUSH); end
        tick();
        @(negedge clk);
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL single_state_c4: got %0d want %0d", fsm_state, S_IDLE); end
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        trap_valid = 1; trap_pc = 32'h8000_0004;
        br_valid = 1; br_pc = 32'h200; br_epoch = 3'd0;
        rpl_valid = 1; rpl_pc = 32'h300; rpl_epoch = 3'd0;
        @(negedge clk);
        checks++; if ({trap_ready, br_ready, rpl_ready} !== 3'b100) begin errors++; $display("FAIL prio_readies_c0: got %b want 100", {trap_ready, br_ready, rpl_ready}); end
        tick();
        trap_valid = 0; arb_tx_ready = 1;
        @(negedge clk);
        checks++; if (arb_tx_pc !== 32'h8000_0004) begin errors++; $display("FAIL prio_pc_c1: got %h want 80000004", arb_tx_pc); end
        checks++; if ({br_ready, rpl_ready} !== 2'b00) begin errors++; $display("FAIL prio_hold_c1: got %b want 00", {br_ready, rpl_ready}); end
        tick();
        @(negedge clk);
        checks++; if (cur_epoch !== 3'd1) begin errors++; $display("FAIL prio_epoch_c2: got %0d want 1", cur_epoch); end
        checks++; if ({br_ready, rpl_ready} !== 2'b11) begin errors++; $display("FAIL prio_stale_drop_c2: got %b want 11", {br_ready, rpl_ready}); end
        tick();
        br_valid = 0; rpl_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (arb_tx_valid !== 1'b0) begin errors++; $display("FAIL prio_no_issue_%0d: got %0b want 0", i, arb_tx_valid); end
            tick();
        end
        @(negedge clk);
        checks++; if (redirect_cnt !== 32'd1) begin errors++; $display("FAIL prio_cnt: got %0d want 1", redirect_cnt); end
        tick();
    endtask

    task automatic test_trap_overwrite();
        do_reset();
        br_valid = 1; br_pc = 32'h400; br_epoch = 3'd0;
        @(negedge clk);
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL ovw_br_ready: got %0b want 1", br_ready); end
        tick();
        br_valid = 0; trap_valid = 1; trap_pc = 32'h8000_0004;
        @(negedge clk);
        checks++; if (arb_tx_pc !== 32'h400) begin errors++; $display("FAIL ovw_pc_c1: got %h want 400", arb_tx_pc); end
        checks++; if (trap_ready !== 1'b1) begin errors++; $display("FAIL ovw_trap_ready_c1: got %0b want 1", trap_ready); end
        tick();
        trap_pc = 32'h8000_0008;
        @(negedge clk);
        checks++; if (arb_tx_pc !== 32'h8000_0004) begin errors++; $display("FAIL ovw_pc_c2: got %h want 80000004", arb_tx_pc); end
        checks++; if (trap_ready !== 1'b0) begin errors++; $display("FAIL ovw_second_trap_c2: got %0b want 0", trap_ready); end
        tick();
        trap_valid = 0; arb_tx_ready = 1;
        @(negedge clk);
        checks++; if (arb_tx_pc !== 32'h8000_0004) begin errors++; $display("FAIL ovw_pc_c3: got %h want 80000004", arb_tx_pc); end
        checks++; if (redirect_cnt !== 32'd0) begin errors++; $display("FAIL ovw_cnt_c3: got %0d want 0", redirect_cnt); end
        tick();
        @(negedge clk);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL ovw_flush_c4: got %0b want 1", flush); end
        tick();
        tick();
        @(negedge clk);
        checks++; if (redirect_cnt !== 32'd1) begin errors++; $display("FAIL ovw_cnt_final: got %0d want 1", redirect_cnt); end
        checks++; if (arb_tx_valid !== 1'b0) begin errors++; $display("FAIL ovw_valid_final: got %0b want 0", arb_tx_valid); end
        tick();
    endtask

    task automatic test_flush_window();
        do_reset();
        arb_tx_ready = 1;
        br_valid = 1; br_pc = 32'h600; br_epoch = 3'd0;
        tick();
        br_valid = 0;
        tick();
        rpl_valid = 1; rpl_pc = 32'h700; rpl_epoch = 3'd1;
        @(negedge clk);
        checks++; if (fsm_state !== S_FLUSH) begin errors++; $display("FAIL fw_state_c2: got %0d want %0d", fsm_state, S_FLUSH); end
        checks++; if (rpl_ready !== 1'b0) begin errors++; $display("FAIL fw_rpl_ready_c2: got %0b want 0", rpl_ready); end
        tick();
        @(negedge clk);
        checks++; if (rpl_ready !== 1'b0) begin errors++; $display("FAIL fw_rpl_ready_c3: got %0b want 0", rpl_ready); end
        tick();
        @(negedge clk);
        checks++; if (rpl_ready !== 1'b1) begin errors++; $display("FAIL fw_rpl_ready_c4: got %0b want 1", rpl_ready); end
        tick();
        rpl_valid = 0;
        @(negedge clk);
        checks++; if (arb_tx_pc !== 32'h700) begin errors++; $display("FAIL fw_rpl_pc_c5: got %h want 700", arb_tx_pc); end
        tick();
        trap_valid = 1; trap_pc = 32'h8000_0010;
        @(negedge clk);
        checks++; if (trap_ready !== 1'b1) begin errors++; $display("FAIL fw_trap_ready_c6: got %0b want 1", trap_ready); end
        tick();
        trap_valid = 0;
        @(negedge clk);
        checks++; if (arb_tx_valid !== 1'b1) begin errors++; $display("FAIL fw_trap_valid_c7: got %0b want 1", arb_tx_valid); end
        checks++; if (arb_tx_pc !== 32'h8000_0010) begin errors++; $display("FAIL fw_trap_pc_c7: got %h want 80000010", arb_tx_pc); end
        tick();
        @(negedge clk);
        checks++; if (redirect_cnt !== 32'd3) begin errors++; $display("FAIL fw_cnt_c8: got %0d want 3", redirect_cnt); end
        checks++; if (cur_epoch !== 3'd3) begin errors++; $display("FAIL fw_epoch_c8: got %0d want 3", cur_epoch); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        arb_tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            br_valid = 1; br_epoch = EPOCH_W'(i); br_pc = 32'h1000 + 32'(i * 4);
            @(negedge clk);
            checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %0b want 1", i, br_ready); end
            tick();
            br_valid = 0;
            @(negedge clk);
            checks++; if (arb_tx_pc !== 32'h1000 + 32'(i * 4)) begin errors++; $display("FAIL b2b_pc_%0d: got %h want %h", i, arb_tx_pc, 32'h1000 + 32'(i * 4)); end
            tick();
            @(negedge clk);
            checks++; if (cur_epoch !== EPOCH_W'((i + 1) % 8)) begin errors++; $display("FAIL b2b_epoch_%0d: got %0d want %0d", i, cur_epoch, (i + 1) % 8); end
            tick();
            tick();
        end
        br_valid = 1; br_epoch = 3'd7; br_pc = 32'h9999_0000;
        @(negedge clk);
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL b2b_stale_ready: got %0b want 1", br_ready); end
        tick();
        br_valid = 0;
        @(negedge clk);
        checks++; if (arb_tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_stale_issue: got %0b want 0", arb_tx_valid); end
        checks++; if (redirect_cnt !== 32'd8) begin errors++; $display("FAIL b2b_cnt: got %0d want 8", redirect_cnt); end
        checks++; if (cur_epoch !== 3'd0) begin errors++; $display("FAIL b2b_wrap_epoch: got %0d want 0", cur_epoch); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        arb_tx_ready = 1;
        br_valid = 1; br_pc = 32'h100; br_epoch = 3'd0;
        tick();
        br_valid = 0;
        tick();
        arb_tx_ready = 0;
        tick();
        tick();
        br_valid = 1; br_pc = 32'h500; br_epoch = 3'd1;
        tick();
        br_valid = 0;
        @(negedge clk);
        checks++; if (arb_tx_pc !== 32'h500) begin errors++; $display("FAIL rmid_pend_pc: got %h want 500", arb_tx_pc); end
        tick();
        rst = 1; trap_valid = 1; trap_pc = 32'h8000_0020;
        br_valid = 1; br_epoch = 3'd5; rpl_valid = 1; rpl_epoch = 3'd1;
        @(negedge clk);
        checks++; if ({trap_ready, br_ready, rpl_ready} !== 3'b000) begin errors++; $display("FAIL rmid_readies_c0: got %b want 000", {trap_ready, br_ready, rpl_ready}); end
        tick();
        @(negedge clk);
        checks++; if (arb_tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b want 0", arb_tx_valid); end
        checks++; if (cur_epoch !== 3'd0) begin errors++; $display("FAIL rmid_epoch: got %0d want 0", cur_epoch); end
        checks++; if (redirect_cnt !== 32'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", redirect_cnt); end
        checks++; if ({trap_ready, br_ready, rpl_ready} !== 3'b000) begin errors++; $display("FAIL rmid_readies_c1: got %b want 000", {trap_ready, br_ready, rpl_ready}); end
        clear_inputs();
        rst = 0;
        tick();
    endtask

    task automatic test_random();
        state_t exp_state;
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            trap_valid   = ($urandom_range(0, 7) == 0);
            trap_pc      = $urandom() & 32'hFFFF_FFFC;
            br_valid     = ($urandom_range(0, 2) == 0);
            br_pc        = $urandom() & 32'hFFFF_FFFC;
            br_epoch     = $urandom_range(0, 1) ? EPOCH_W'(m_epoch) : EPOCH_W'($urandom());
            rpl_valid    = ($urandom_range(0, 2) == 0);
            rpl_pc       = $urandom() & 32'hFFFF_FFFC;
            rpl_epoch    = $urandom_range(0, 1) ? EPOCH_W'(m_epoch) : EPOCH_W'($urandom());
            arb_tx_ready = $urandom_range(0, 1);
            @(negedge clk);
            model_eval();
            exp_state = m_pend ? S_PEND : ((m_settle > 0) ? S_FLUSH : S_IDLE);
            checks++; if (trap_ready !== e_trap_rdy) begin errors++; $display("FAIL rnd_trap_ready @%0d: got %0b want %0b", n, trap_ready, e_trap_rdy); end
            checks++; if (br_ready !== e_br_rdy) begin errors++; $display("FAIL rnd_br_ready @%0d: got %0b want %0b", n, br_ready, e_br_rdy); end
            checks++; if (rpl_ready !== e_rpl_rdy) begin errors++; $display("FAIL rnd_rpl_ready @%0d: got %0b want %0b", n, rpl_ready, e_rpl_rdy); end
            checks++; if (arb_tx_valid !== m_pend) begin errors++; $display("FAIL rnd_valid @%0d: got %0b want %0b", n, arb_tx_valid, m_pend); end
            checks++; if (arb_tx_pc !== m_pc) begin errors++; $display("FAIL rnd_pc @%0d: got %h want %h", n, arb_tx_pc, m_pc); end
            checks++; if (flush !== m_flush) begin errors++; $display("FAIL rnd_flush @%0d: got %0b want %0b", n, flush, m_flush); end
            checks++; if (cur_epoch !== EPOCH_W'(m_epoch)) begin errors++; $display("FAIL rnd_epoch @%0d: got %0d want %0d", n, cur_epoch, m_epoch); end
            checks++; if (redirect_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, redirect_cnt, m_cnt); end
            checks++; if (fsm_state !== exp_state) begin errors++; $display("FAIL rnd_state @%0d: got %0d want %0d", n, fsm_state, exp_state); end
            model_update();
            tick();
        end
        clear_inputs();
        rst = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        #1;
        test_reset();
        test_single_br();
        test_priority();
        test_trap_overwrite();
        test_flush_window();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Arbitrates and sequences PC redirect requests from three sources into the single branch-correction input of the PC register. Sources are trap/CSR, EXU branch/jump, and LSU replay (fence.i / memory-order replay). It keeps a fetch epoch so that requests from wrong-path instructions are dropped. After every issued redirect it emits a flush pulse and enforces a settle window. It sits between EXU/LSU/CSR and the PC register; its output drives the PC register's redirect valid/ready/pc port.

Parameters:
EPOCH_W, 3, width of fetch epoch tag; wraps modulo 2^EPOCH_W
FLUSH_CYCLES, 2, settle cycles after a redirect handshake before non-trap requests are accepted again (min 1)
CNT_W, 32, width of redirect performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
trap_valid  in  1  trap/mret redirect request
trap_ready  out  1  trap request accepted
trap_pc  in  32  trap target
br_valid  in  1  EXU mispredict/jump redirect request
br_ready  out  1  EXU request accepted (issued or dropped)
br_pc  in  32  EXU target
br_epoch  in  EPOCH_W  epoch of the redirecting instruction
rpl_valid  in  1  LSU replay request
rpl_ready  out  1  LSU request accepted (issued or dropped)
rpl_pc  in  32  replay target
rpl_epoch  in  EPOCH_W  epoch of the replaying instruction
arb_tx_valid  out  1  redirect to PC register
arb_tx_ready  in  1  PC register accepts redirect
arb_tx_pc  out  32  redirect target
flush  out  1  one-cycle pulse; IFU/decode discard in-flight instructions
cur_epoch  out  EPOCH_W  current fetch epoch; IFU tags fetched instructions with it
redirect_cnt  out  CNT_W  number of completed redirect handshakes

Behaviour:
- Reset (rst=1 at clk edge): state=S_IDLE; arb_tx_valid=0; arb_tx_pc=0; flush=0; cur_epoch=0; redirect_cnt=0; flush counter=0. All ready outputs are 0 while rst=1. Reset mid-operation discards any pending redirect.
- Stale request: a br or rpl request whose epoch differs from cur_epoch. When rst=0, a stale request gets ready=1 in every state and is dropped. It has no effect on any output.
- Fresh request: a br or rpl request whose epoch equals cur_epoch. Trap requests are always fresh.
- Priority among same-cycle fresh requests: trap > br > rpl. Only the winner gets ready=1. Fresh losers see ready=0 and hold.
- States:
  - S_IDLE: accepts the winner. Next cycle: arb_tx_pc=winner pc, arb_tx_valid=1, state goes to S_PEND (latency 1). With no fresh request, stays in S_IDLE.
  - S_PEND: arb_tx_valid=1; arb_tx_pc is stable, except for the trap overwrite below. br and rpl fresh requests get ready=0.
    - Trap overwrite: if the pending source is not trap, a trap request gets ready=1 and replaces arb_tx_pc next cycle. It is the only allowed change of pc while valid=1. If the pending source is trap, trap_ready=0.
    - On arb_tx_valid && arb_tx_ready: next cycle arb_tx_valid=0, flush=1 for exactly one cycle, cur_epoch incremented (wraps), redirect_cnt incremented (wraps), flush counter loaded with FLUSH_CYCLES, state goes to S_FLUSH.
    - If a trap arrives in the same cycle as the handshake, the trap is not accepted (trap_ready=0); it is taken in S_FLUSH.
  - S_FLUSH: counter decrements each cycle; state goes to S_IDLE when the counter reaches 1.
    - A trap request is accepted (trap_ready=1) and moves the block straight to S_PEND with valid=1 next cycle.
    - Fresh br/rpl requests see ready=0.
- Same-cycle br and rpl when both are stale: both get ready=1 and both are dropped.
- Epoch wrap: after 2^EPOCH_W redirects, cur_epoch returns to 0; stale comparison uses equality only.
- arb_tx_ready is ignored when arb_tx_valid=0.

Decomposition:
- Shared define include (alongside the instruction defines) holds:
  - state encodings S_IDLE=2'd0, S_PEND=2'd1, S_FLUSH=2'd2;
  - source IDs SRC_TRAP=2'd0, SRC_BR=2'd1, SRC_RPL=2'd2;
  - default EPOCH_W and FLUSH_CYCLES.
- One sub-module, pc_redirect_prio: combinational stale filter plus fixed-priority picker. Outputs are winner valid, winner source ID, winner pc and per-source drop flags. The FSM, epoch, counters and output registers stay in pc_redirect_ctrl.

Test Plan:
- Reset, then br_valid=1, br_pc=0x80000100, br_epoch=0, tx_ready=1 -> br_ready=1 cycle 0; arb_tx_valid=1, pc=0x80000100 cycle 1; flush=1, cur_epoch=1, redirect_cnt=1 cycle 2; S_IDLE after 2 flush cycles.
- Same cycle: trap_pc=0x80000004, br_pc=0x200, rpl_pc=0x300, all epoch 0 -> only trap_ready=1; tx_pc=0x80000004. br and rpl still held; after flush they are stale (epoch 1) and are dropped with ready=1, without issuing a redirect.
- tx_ready=0 with br pending at 0x400; trap at 0x80000004 arrives -> trap_ready=1, arb_tx_pc=0x80000004 next cycle; a second trap sees trap_ready=0; tx_ready=1 then issues a single redirect, redirect_cnt=1.
- During S_FLUSH: fresh rpl (epoch=cur_epoch) sees rpl_ready=0 until S_IDLE. A trap in S_FLUSH is accepted immediately, with arb_tx_valid=1 next cycle.
- Eight back-to-back br redirects with EPOCH_W=3 -> cur_epoch sequence 1..7,0. A br with epoch 7 after the wrap is dropped, and redirect_cnt=8.
- Assert rst while in S_PEND with tx_ready=0 -> next cycle arb_tx_valid=0, cur_epoch=0, redirect_cnt=0, all readies 0 while rst=1.
